// File: rtl/clkdiv_switch.sv
// Programmable master-clock divider for the Z80 clock pin.
// Ratio changes and stop/resume land only on the LO->HI boundary, so clkout never glitches.
module clkdiv_switch #(
    parameter int          DIVW    = 4,
    parameter int unsigned DEF_DIV = 0
) (
    input  logic            clk,
    input  logic            coldres_n,
    input  logic [DIVW-1:0] div_req,
    input  logic            req,
    input  logic            stop,
    output logic            busy,
    output logic            ack,
    output logic [DIVW-1:0] cur_div,
    output logic            clkout,
    output logic            rise_stb,
    output logic            fall_stb,
    output logic            stopped
);

    typedef enum logic [1:0] {LO, HI, STOP} state_t;

    state_t          state;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] pend;

    always_ff @(posedge clk or negedge coldres_n) begin
        if (!coldres_n) begin
            state    <= LO;
            cnt      <= '0;
            pend     <= '0;
            cur_div  <= DIVW'(DEF_DIV);
            busy     <= 1'b0;
            ack      <= 1'b0;
            clkout   <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            stopped  <= 1'b0;
        end else begin
            ack      <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;

            // A request latched on a boundary cycle sees busy=0 here and
            // is therefore held for the following boundary.
            if (req && !busy) begin
                pend <= div_req;
                busy <= 1'b1;
            end

            case (state)
                LO: begin
                    if (cnt == cur_div) begin
                        cnt <= '0;
                        if (stop) begin
                            state   <= STOP;
                            stopped <= 1'b1;
                        end else begin
                            state    <= HI;
                            clkout   <= 1'b1;
                            rise_stb <= 1'b1;
                            if (busy) begin
                                cur_div <= pend;
                                busy    <= 1'b0;
                                ack     <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + DIVW'(1);
                    end
                end
                HI: begin
                    if (cnt == cur_div) begin
                        cnt      <= '0;
                        state    <= LO;
                        clkout   <= 1'b0;
                        fall_stb <= 1'b1;
                    end else begin
                        cnt <= cnt + DIVW'(1);
                    end
                end
                STOP: begin
                    cnt    <= '0;
                    clkout <= 1'b0;
                    if (!stop) begin
                        state   <= LO;
                        stopped <= 1'b0;
                    end
                end
                default: begin
                    state  <= LO;
                    cnt    <= '0;
                    clkout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_switch.sv
// Bench for clkdiv_switch: directed scenarios plus random traffic against a
// phase-countdown reference model.
module tb_clkdiv_switch;

    localparam int DIVW    = 4;
    localparam int DEF_DIV = 0;

    logic            clk;
    logic            coldres_n;
    logic [DIVW-1:0] div_req;
    logic            req;
    logic            stop;
    logic            busy;
    logic            ack;
    logic [DIVW-1:0] cur_div;
    logic            clkout;
    logic            rise_stb;
    logic            fall_stb;
    logic            stopped;

    int checks   = 0;
    int failures = 0;

    clkdiv_switch #(.DIVW(DIVW), .DEF_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .coldres_n(coldres_n),
        .div_req  (div_req),
        .req      (req),
        .stop     (stop),
        .busy     (busy),
        .ack      (ack),
        .cur_div  (cur_div),
        .clkout   (clkout),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .stopped  (stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each phase lasts (ratio+1) cycles, counted down.
    logic            m_clk, m_rise, m_fall, m_ack, m_busy, m_stopped, m_in_stop;
    logic [DIVW-1:0] m_cur, m_pend;
    int              m_rem;

    task automatic model_reset();
        m_clk = 0; m_rise = 0; m_fall = 0; m_ack = 0; m_busy = 0;
        m_stopped = 0; m_in_stop = 0;
        m_cur = DIVW'(DEF_DIV); m_pend = '0;
        m_rem = DEF_DIV + 1;
    endtask

    task automatic model_step(input logic r, input logic [DIVW-1:0] d, input logic s);
        logic            was_busy;
        logic [DIVW-1:0] old_pend;
        was_busy = m_busy;
        old_pend = m_pend;
        m_rise = 0; m_fall = 0; m_ack = 0;
        if (r && !was_busy) begin
            m_pend = d;
            m_busy = 1;
        end
        if (m_in_stop) begin
            if (!s) begin
                m_in_stop = 0;
                m_stopped = 0;
                m_rem     = int'(m_cur) + 1;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_clk) begin
                    m_clk  = 0;
                    m_fall = 1;
                    m_rem  = int'(m_cur) + 1;
                end else if (s) begin
                    m_in_stop = 1;
                    m_stopped = 1;
                end else begin
                    if (was_busy) begin
                        m_cur  = old_pend;
                        m_busy = 0;
                        m_ack  = 1;
                    end
                    m_clk  = 1;
                    m_rise = 1;
                    m_rem  = int'(m_cur) + 1;
                end
            end
        end
    endtask

    function automatic logic [9:0] obs();
        return {clkout, rise_stb, fall_stb, busy, ack, stopped, cur_div};
    endfunction

    function automatic logic [9:0] expv();
        return {m_clk, m_rise, m_fall, m_busy, m_ack, m_stopped, m_cur};
    endfunction

    // Drive inputs just after an edge, let the next edge take them, sample 1ns later.
    task automatic tick(input logic r, input logic [DIVW-1:0] d, input logic s);
        req = r; div_req = d; stop = s;
        @(posedge clk);
        model_step(r, d, s);
        #1;
    endtask

    task automatic test_reset();
        coldres_n = 0; req = 0; div_req = '0; stop = 0;
        model_reset();
        #2;
        checks++;
        if (obs() !== 10'b0) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs(), 10'b0);
        end
        @(posedge clk); #1;
        coldres_n = 1;
        tick(0, 0, 0);
        checks++;
        if (clkout !== 1'b1 || rise_stb !== 1'b1) begin
            failures++;
            $display("FAIL first_rise clkout=%b rise=%b want 1 1", clkout, rise_stb);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs() !== expv() || rise_stb !== clkout || fall_stb !== !clkout) begin
                failures++;
                $display("FAIL div0_alternate i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_ratio_change();
        int n;
        n = 0;
        while (!clkout && n < 4) begin tick(0, 0, 0); n++; end
        tick(1, 2, 0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL req_busy got=%b want=1", busy);
        end
        n = 0;
        while (!ack && n < 5) begin tick(0, 0, 0); n++; end
        checks++;
        if (ack !== 1'b1 || rise_stb !== 1'b1 || cur_div !== 4'd2 || n != 1) begin
            failures++;
            $display("FAIL ack_at_boundary ack=%b rise=%b cur=%0d wait=%0d want 1 1 2 1",
                     ack, rise_stb, cur_div, n);
        end
        for (int i = 1; i < 12; i++) begin
            tick(0, 0, 0);
            checks++;
            if (clkout !== ((i % 6) < 3) || obs() !== expv()) begin
                failures++;
                $display("FAIL period6 i=%0d clkout=%b want=%b got=%b model=%b",
                         i, clkout, (i % 6) < 3, obs(), expv());
            end
        end
    endtask

    task automatic test_ignore_busy();
        int acks;
        acks = 0;
        tick(1, 2, 0);
        if (ack) acks++;
        tick(1, 5, 0);
        if (ack) acks++;
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            if (ack) acks++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL ignore_busy_model i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
        checks++;
        if (acks != 1 || cur_div !== 4'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_busy acks=%0d cur=%0d busy=%b want 1 2 0", acks, cur_div, busy);
        end
    endtask

    task automatic test_coincident();
        int n;
        tick(1, 1, 0);
        n = 0;
        while (!ack && n < 10) begin tick(0, 0, 0); n++; end
        checks++;
        if (cur_div !== 4'd1) begin
            failures++;
            $display("FAIL set_div1 cur=%0d want=1", cur_div);
        end
        n = 0;
        while (!fall_stb && n < 6) begin tick(0, 0, 0); n++; end
        tick(0, 0, 0);
        tick(1, 3, 0);
        checks++;
        if (rise_stb !== 1'b1 || ack !== 1'b0 || busy !== 1'b1 || cur_div !== 4'd1) begin
            failures++;
            $display("FAIL coincident_req rise=%b ack=%b busy=%b cur=%0d want 1 0 1 1",
                     rise_stb, ack, busy, cur_div);
        end
        n = 0;
        tick(0, 0, 0);
        while (!rise_stb && n < 8) begin tick(0, 0, 0); n++; end
        checks++;
        if (ack !== 1'b1 || cur_div !== 4'd3 || obs() !== expv()) begin
            failures++;
            $display("FAIL coincident_apply ack=%b cur=%0d want 1 3 got=%b model=%b",
                     ack, cur_div, obs(), expv());
        end
    endtask

    task automatic test_stop();
        int n;
        tick(1, 2, 0);
        n = 0;
        while (!ack && n < 12) begin tick(0, 0, 0); n++; end
        n = 0;
        while (!stopped && n < 12) begin
            tick(0, 0, 1);
            n++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stop_entry_model n=%0d got=%b want=%b", n, obs(), expv());
            end
        end
        checks++;
        if (n != 6 || clkout !== 1'b0 || cur_div !== 4'd2) begin
            failures++;
            $display("FAIL stop_entry cycles=%0d clkout=%b cur=%0d want 6 0 2", n, clkout, cur_div);
        end
        for (int i = 0; i < 4; i++) begin
            tick(i == 1, 1, 1);
            checks++;
            if (clkout !== 1'b0 || stopped !== 1'b1 || busy !== (i >= 1)) begin
                failures++;
                $display("FAIL parked i=%0d clkout=%b stopped=%b busy=%b", i, clkout, stopped, busy);
            end
        end
        tick(0, 0, 0);
        checks++;
        if (stopped !== 1'b0 || clkout !== 1'b0) begin
            failures++;
            $display("FAIL stop_exit stopped=%b clkout=%b want 0 0", stopped, clkout);
        end
        n = 0;
        while (!rise_stb && n < 10) begin tick(0, 0, 0); n++; end
        checks++;
        if (n != 3 || ack !== 1'b1 || cur_div !== 4'd1) begin
            failures++;
            $display("FAIL resume_rise wait=%0d ack=%b cur=%0d want 3 1 1", n, ack, cur_div);
        end
        for (int i = 1; i < 9; i++) begin
            tick(0, 0, 0);
            checks++;
            if (clkout !== ((i % 4) < 2) || obs() !== expv()) begin
                failures++;
                $display("FAIL period4 i=%0d clkout=%b got=%b model=%b", i, clkout, obs(), expv());
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!rise_stb && n < 6) begin tick(0, 0, 0); n++; end
        tick(1, 4, 0);
        checks++;
        if (clkout !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset clkout=%b busy=%b want 1 1", clkout, busy);
        end
        #2;
        coldres_n = 0;
        model_reset();
        #1;
        checks++;
        if (clkout !== 1'b0 || busy !== 1'b0 || cur_div !== 4'(DEF_DIV)) begin
            failures++;
            $display("FAIL async_reset clkout=%b busy=%b cur=%0d want 0 0 %0d",
                     clkout, busy, cur_div, DEF_DIV);
        end
        @(posedge clk); #1;
        coldres_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs() !== expv() || (i == DEF_DIV && rise_stb !== 1'b1)) begin
                failures++;
                $display("FAIL post_reset i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_random();
        logic s;
        s = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 4) s = ~s;
            tick($urandom_range(99) < 15, DIVW'($urandom_range(15)), s);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random i=%0d got=%b want=%b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ratio_change();
        test_ignore_busy();
        test_coincident();
        test_stop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
